// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT butterfly datapath:
// default word widths, unity twiddle, saturation and lane packing offset.
package fft_pkg;

    localparam int N_DEF  = 16;
    localparam int Q_DEF  = 14;
    localparam int TW_ONE = 1 << Q_DEF;

    // Clamp a wide signed value into the range of an n-bit two's complement word.
    function automatic logic signed [63:0] sat_n(input logic signed [63:0] x,
                                                 input int unsigned n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    function automatic int unsigned lane_off(input int unsigned k, input int unsigned n);
        return k * n;
    endfunction

endpackage

// File: rtl/fft_bfly_lane.sv
// Single-lane 3-stage radix-2 DIT butterfly datapath (register, multiply, combine).
// Build option FFT_BFLY_ROUND_EN: round half up before the >>Q product shift.
module fft_bfly_lane
    import fft_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_scl,
    input  logic signed [N-1:0] i_ar,
    input  logic signed [N-1:0] i_ai,
    input  logic signed [N-1:0] i_br,
    input  logic signed [N-1:0] i_bi,
    input  logic signed [N-1:0] i_wr,
    input  logic signed [N-1:0] i_wi,
    output logic signed [N-1:0] o_y0r,
    output logic signed [N-1:0] o_y0i,
    output logic signed [N-1:0] o_y1r,
    output logic signed [N-1:0] o_y1i,
    output logic                o_sat
);

    localparam int PW = 2 * N;
    // Wide enough that a + (b*w >> Q) can never wrap before saturation.
    localparam int SW = 2 * N + 3;

`ifdef FFT_BFLY_ROUND_EN
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (Q - 1);
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    logic signed [N-1:0]  r_ar_p0, r_ai_p0, r_br_p0, r_bi_p0, r_wr_p0, r_wi_p0;
    logic                 r_scl_p0;
    logic signed [PW-1:0] r_rr_p1, r_ii_p1, r_ri_p1, r_ir_p1;
    logic signed [N-1:0]  r_ar_p1, r_ai_p1;
    logic                 r_scl_p1;
    logic signed [N-1:0]  r_y0r_p2, r_y0i_p2, r_y1r_p2, r_y1i_p2;

    logic signed [SW-1:0] w_pr, w_pi, w_p_r, w_p_i;
    logic signed [SW-1:0] w_t [4];
    logic signed [N-1:0]  w_y  [4];
    logic                 w_sat;

    // S1: capture operands
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ar_p0  <= '0;
            r_ai_p0  <= '0;
            r_br_p0  <= '0;
            r_bi_p0  <= '0;
            r_wr_p0  <= '0;
            r_wi_p0  <= '0;
            r_scl_p0 <= 1'b0;
        end else if (i_en) begin
            r_ar_p0  <= i_ar;
            r_ai_p0  <= i_ai;
            r_br_p0  <= i_br;
            r_bi_p0  <= i_bi;
            r_wr_p0  <= i_wr;
            r_wi_p0  <= i_wi;
            r_scl_p0 <= i_scl;
        end
    end

    // S2: four partial products
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_p1  <= '0;
            r_ii_p1  <= '0;
            r_ri_p1  <= '0;
            r_ir_p1  <= '0;
            r_ar_p1  <= '0;
            r_ai_p1  <= '0;
            r_scl_p1 <= 1'b0;
        end else if (i_en) begin
            r_rr_p1  <= PW'(r_br_p0) * PW'(r_wr_p0);
            r_ii_p1  <= PW'(r_bi_p0) * PW'(r_wi_p0);
            r_ri_p1  <= PW'(r_br_p0) * PW'(r_wi_p0);
            r_ir_p1  <= PW'(r_bi_p0) * PW'(r_wr_p0);
            r_ar_p1  <= r_ar_p0;
            r_ai_p1  <= r_ai_p0;
            r_scl_p1 <= r_scl_p0;
        end
    end

    // S3: complex product, sum/difference, optional halving, saturation
    always_comb begin
        w_pr   = SW'(r_rr_p1) - SW'(r_ii_p1) + RND;
        w_pi   = SW'(r_ri_p1) + SW'(r_ir_p1) + RND;
        w_p_r  = w_pr >>> Q;
        w_p_i  = w_pi >>> Q;
        w_t[0] = SW'(r_ar_p1) + w_p_r;
        w_t[1] = SW'(r_ai_p1) + w_p_i;
        w_t[2] = SW'(r_ar_p1) - w_p_r;
        w_t[3] = SW'(r_ai_p1) - w_p_i;
        w_sat  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_scl_p1)
                w_t[i] = w_t[i] >>> 1;
            w_y[i] = N'(sat_n(64'(w_t[i]), N));
            if (sat_n(64'(w_t[i]), N) != 64'(w_t[i]))
                w_sat = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y0r_p2 <= '0;
            r_y0i_p2 <= '0;
            r_y1r_p2 <= '0;
            r_y1i_p2 <= '0;
        end else if (i_en) begin
            r_y0r_p2 <= w_y[0];
            r_y0i_p2 <= w_y[1];
            r_y1r_p2 <= w_y[2];
            r_y1i_p2 <= w_y[3];
        end
    end

    assign o_y0r = r_y0r_p2;
    assign o_y0i = r_y0i_p2;
    assign o_y1r = r_y1r_p2;
    assign o_y1i = r_y1i_p2;
    assign o_sat = w_sat;

endmodule

// File: rtl/fft_bfly_stage_n.sv
// Pipelined LANES-wide radix-2 DIT butterfly stage with valid/ready handshake and sticky ovf.
// Build option FFT_BFLY_ROUND_EN selects round-half-up on the twiddle product.
module fft_bfly_stage_n
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int Q     = Q_DEF,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 scale_en,
    input  logic [LANES*N-1:0]   a_r,
    input  logic [LANES*N-1:0]   a_i,
    input  logic [LANES*N-1:0]   b_r,
    input  logic [LANES*N-1:0]   b_i,
    input  logic [LANES*N-1:0]   w_r,
    input  logic [LANES*N-1:0]   w_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   y0_r,
    output logic [LANES*N-1:0]   y0_i,
    output logic [LANES*N-1:0]   y1_r,
    output logic [LANES*N-1:0]   y1_i,
    output logic                 ovf
);

    logic             w_adv;
    logic [LANES-1:0] w_sat;
    logic             r_vld_p0, r_vld_p1, r_vld_p2;
    logic             r_ovf;

    // The whole pipe moves as one; bubbles advance too so latency stays fixed.
    assign w_adv    = !r_vld_p2 || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_adv) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            // Only a real beat entering the output stage may flag saturation.
            r_ovf    <= r_ovf | (r_vld_p1 & (|w_sat));
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned OFF = lane_off(k, N);
        fft_bfly_lane #(
            .N (N),
            .Q (Q)
        ) u_lane (
            .i_clk (clk),
            .i_rst (rst),
            .i_en  (w_adv),
            .i_scl (scale_en),
            .i_ar  (a_r[OFF +: N]),
            .i_ai  (a_i[OFF +: N]),
            .i_br  (b_r[OFF +: N]),
            .i_bi  (b_i[OFF +: N]),
            .i_wr  (w_r[OFF +: N]),
            .i_wi  (w_i[OFF +: N]),
            .o_y0r (y0_r[OFF +: N]),
            .o_y0i (y0_i[OFF +: N]),
            .o_y1r (y1_r[OFF +: N]),
            .o_y1i (y1_i[OFF +: N]),
            .o_sat (w_sat[k])
        );
    end

    assign out_valid = r_vld_p2;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_fft_bfly_stage_n.sv
// Directed self-checking bench for fft_bfly_stage_n (N=16, Q=14, LANES=4).
// Expectations follow FFT_BFLY_ROUND_EN when it is defined for the build.
module tb_fft_bfly_stage_n;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int W     = N * LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, scale_en, out_valid, out_ready, ovf;
    logic [W-1:0] a_r, a_i, b_r, b_i, w_r, w_i;
    logic [W-1:0] y0_r, y0_i, y1_r, y1_i;

    int errors = 0;
    int checks = 0;

    fft_bfly_stage_n #(.N(16), .Q(14), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scale_en  (scale_en),
        .a_r       (a_r),
        .a_i       (a_i),
        .b_r       (b_r),
        .b_i       (b_i),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0_r      (y0_r),
        .y0_i      (y0_i),
        .y1_r      (y1_r),
        .y1_i      (y1_i),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [N-1:0] lane(input logic [W-1:0] v, input int k);
        return v[k*N +: N];
    endfunction

    task automatic set_lane(input int k, input int ar, input int ai, input int br,
                            input int bi, input int wr, input int wi);
        a_r[k*N +: N] = 16'(ar);
        a_i[k*N +: N] = 16'(ai);
        b_r[k*N +: N] = 16'(br);
        b_i[k*N +: N] = 16'(bi);
        w_r[k*N +: N] = 16'(wr);
        w_i[k*N +: N] = 16'(wi);
    endtask

    task automatic clear_lanes();
        a_r = '0; a_i = '0; b_r = '0; b_i = '0; w_r = '0; w_i = '0;
    endtask

    // Present one beat (out_ready held high, so it is accepted at the next edge)
    // and return at the falling edge where it is on the outputs.
    task automatic push_and_wait(input logic scl);
        @(negedge clk);
        in_valid = 1'b1;
        scale_en = scl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("out_valid_latency3", longint'(out_valid), 1);
    endtask

    logic [39:0] pat;
    int          sent, rcv;
    logic        acc;
    int          rnd_exp;

    initial begin
        rst = 1'b1; in_valid = 1'b0; scale_en = 1'b0; out_ready = 1'b1;
        clear_lanes();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_y0_r", longint'(y0_r), 0);
        chk("reset_y1_i", longint'(y1_i), 0);
        chk("reset_ovf", longint'(ovf), 0);
        chk("reset_in_ready", longint'(in_ready), 1);

        // Basic: a=4096, b=8192, w=1.0
        clear_lanes();
        set_lane(0, 4096, 0, 8192, 0, 16384, 0);
        push_and_wait(1'b0);
        chk("basic_y0r", lane(y0_r, 0), 12288);
        chk("basic_y0i", lane(y0_i, 0), 0);
        chk("basic_y1r", lane(y1_r, 0), -4096);
        chk("basic_y1i", lane(y1_i, 0), 0);
        chk("basic_ovf", longint'(ovf), 0);

        // Twiddle -j, lane0 from the plan, other lanes distinct: w*b = (bi, -br)
        clear_lanes();
        for (int k = 0; k < LANES; k++)
            set_lane(k, 4096 + 100*k, -50*k, 8192 - 1000*k, 300*k, 0, -16384);
        push_and_wait(1'b0);
        for (int k = 0; k < LANES; k++) begin
            chk($sformatf("mj_y0r_l%0d", k), lane(y0_r, k), 4096 + 100*k + 300*k);
            chk($sformatf("mj_y0i_l%0d", k), lane(y0_i, k), -50*k - (8192 - 1000*k));
            chk($sformatf("mj_y1r_l%0d", k), lane(y1_r, k), 4096 + 100*k - 300*k);
            chk($sformatf("mj_y1i_l%0d", k), lane(y1_i, k), -50*k + (8192 - 1000*k));
        end

        // Rounding: 1 * 0.5
        clear_lanes();
        set_lane(0, 0, 0, 1, 0, 8192, 0);
        push_and_wait(1'b0);
`ifdef FFT_BFLY_ROUND_EN
        rnd_exp = 1;
`else
        rnd_exp = 0;
`endif
        chk("round_y0r", lane(y0_r, 0), longint'(rnd_exp));
        chk("round_y0i", lane(y0_i, 0), 0);

        // Scaled beat that would saturate unscaled
        clear_lanes();
        set_lane(0, 20000, 0, 20000, 0, 16384, 0);
        push_and_wait(1'b1);
        chk("scale_y0r", lane(y0_r, 0), 20000);
        chk("scale_y1r", lane(y1_r, 0), 0);
        chk("scale_ovf", longint'(ovf), 0);

        push_and_wait(1'b0);
        chk("sat_y0r", lane(y0_r, 0), 32767);
        chk("sat_y1r", lane(y1_r, 0), 0);
        chk("sat_ovf", longint'(ovf), 1);

        clear_lanes();
        set_lane(0, 4096, 0, 8192, 0, 16384, 0);
        push_and_wait(1'b0);
        chk("sticky_y0r", lane(y0_r, 0), 12288);
        chk("sticky_ovf", longint'(ovf), 1);

        // Backpressure: 10 beats, a passes through (b=w=0)
        pat  = 40'b1101_0000_0111_0110_1011_1111_0011_1010_1101_1110;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 300 && rcv < 10; c++) begin
            @(negedge clk);
            out_ready = pat[c % 40];
            in_valid  = (sent < 10);
            scale_en  = 1'b0;
            clear_lanes();
            for (int k = 0; k < LANES; k++)
                set_lane(k, 100*(sent+1) + k, -(sent+1) - k, 0, 0, 0, 0);
            #1;
            chk("bp_in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_y0r_l0_b%0d", rcv), lane(y0_r, 0), 100*(rcv+1));
                chk($sformatf("bp_y1i_l3_b%0d", rcv), lane(y1_i, 3), -(rcv+1) - 3);
                rcv++;
            end
            @(posedge clk);
            if (acc)
                sent++;
        end
        chk("bp_beats_received", longint'(rcv), 10);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_no_extra_beat", longint'(out_valid), 0);

        // Reset mid-stream: two beats in flight, third presented with rst
        clear_lanes();
        set_lane(0, 1234, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_y0r", lane(y0_r, 0), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_stale_%0d", c), longint'(out_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_bfly_stage_n.md
Name: fft_bfly_stage_n

Overview:
- Parametrised, pipelined radix-2 DIT butterfly stage for the FFT datapath.
- Computes LANES independent butterflies per beat: out0 = a + w·b, out1 = a − w·b.
- Signed fixed-point arithmetic with Q fractional bits, per-beat optional /2 scaling and saturation.
- Uses a valid/ready stream handshake so stages can be chained with backpressure. Intended as the building block for all stages of the 32-point and larger FFTs.

Parameters:
- N, 16, sample/twiddle word width (signed two's complement, real and imag each).
- Q, 14, fractional bits of every word (twiddle 1.0 = 2^Q).
- LANES, 4, number of parallel butterflies per beat (≥1).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- scale_en  in  1  per-beat: divide both butterfly outputs by 2; sampled with the beat.
- a_r, a_i  in  LANES*N  upper-leg inputs; lane k at [k*N +: N].
- b_r, b_i  in  LANES*N  lower-leg inputs.
- w_r, w_i  in  LANES*N  per-lane twiddle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y0_r, y0_i  out  LANES*N  a + w·b per lane.
- y1_r, y1_i  out  LANES*N  a − w·b per lane.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset (rst=1 at clock edge): all stage valid bits 0, all data registers 0, ovf 0. Outputs are therefore out_valid=0, y*=0, ovf=0. in_ready is combinational and equals 1 after reset.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - Beat accepted when in_valid && in_ready.
  - When adv=1, all three pipeline stages shift together, bubbles included.
  - When adv=0, every register holds its value.
- Latency: exactly 3 advancing cycles from acceptance to out_valid. Beats leave in acceptance order, with no loss or duplication under any out_ready pattern.
- S1: register a, b, w, scale_en and valid.
- S2: form four 2N-bit signed products per lane: br·wr, bi·wi, br·wi, bi·wr. Register them.
- S3: compute the complex product and scaling.
  - pr = br·wr − bi·wi and pi = br·wi + bi·wr, in 2N+1 bits.
  - Shift each right by Q (arithmetic) to get p; rounding is per the optional feature.
  - Compute s = a + p and d = a − p at N+2 bits.
  - If scale_en, take s>>>1 and d>>>1 (arithmetic, truncating).
  - Saturate each result to [−2^(N−1), 2^(N−1)−1], then register.
- ovf: set on the cycle an S3 result saturates and S3 valid is set with adv=1. Remains 1 until rst. Saturation of bubble data never sets ovf.
- Simultaneous rst with any handshake: rst wins, and in-flight beats are discarded.
- in_valid without in_ready: upstream holds the beat. Data on lanes is don't-care when in_valid=0.

Optional Feature:
- Macro: FFT_BFLY_ROUND_EN.
- Defined: before the >>Q shift, add 2^(Q−1) to pr/pi (round half up).
- Undefined: plain arithmetic shift (truncate toward −∞).
- Latency and interface are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - default N/Q constants and the twiddle-one constant (1<<Q);
  - the saturate-to-N function;
  - the lane slice helper (lane index → bit offset).
- One sub-module, fft_bfly_lane: a single-lane 3-stage datapath with enable=adv, scale bit and sat flag out.
- Top-level contents: handshake, valid pipeline, generate loop over LANES, and OR-reduction of lane sat flags into ovf.

Test Plan:
- Basic: lane0 a=(4096,0), b=(8192,0), w=(16384,0), out_ready=1 → 3 cycles later y0=(12288,0), y1=(−4096,0), ovf=0.
- Twiddle −j: a=(4096,0), b=(8192,0), w=(0,−16384) → y0=(4096,−8192), y1=(4096,8192). Repeat on every lane with distinct values to check the packing.
- Saturation and scaling:
  - a=b=(20000,0), w=(16384,0), scale_en=0 → y0=(32767,0), y1=(0,0), ovf=1, and ovf stays 1 for later clean beats.
  - Same beat with scale_en=1 → y0=(20000,0), and no ovf set from that beat alone.
- Rounding: a=0, b=(1,0), w=(8192,0) → y0=(1,0) with FFT_BFLY_ROUND_EN defined, (0,0) without.
- Backpressure: stream 10 beats, in_valid=1 continuously, random out_ready (including 5 consecutive low cycles) → all 10 beats emerge in order, unchanged. in_ready=0 exactly when out_valid=1 && out_ready=0.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → next cycle out_valid=0, ovf=0, in_ready=1; no stale beat ever appears.
